// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, MEM FSM states and the
// byte-enable mask helper.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] be_mask(input size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface mem_stage_ls_if #(
    parameter int XLEN = 32
);
    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN-1:0]     dmem_addr;
    logic [XLEN-1:0]     dmem_wdata;
    logic [XLEN/8-1:0]   dmem_be;
    logic [XLEN-1:0]     dmem_rdata;
    logic                dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: shifts the addressed lane down, truncates to the
// access size and sign- or zero-extends to XLEN.
module mem_load_align
    import cpu_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           i_rdata,
    input  logic [$clog2(XLEN/8)-1:0] i_offset,
    input  size_e                     i_size,
    input  logic                      i_unsigned,
    output logic [XLEN-1:0]           o_data
);

    logic [XLEN-1:0] w_sh;
    logic            w_sign;
    int unsigned     w_width;

    assign w_sh = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        w_width = XLEN;
        w_sign  = 1'b0;
        case (i_size)
            SZ_B: begin
                w_width = 8;
                w_sign  = w_sh[7];
            end
            SZ_H: begin
                w_width = 16;
                w_sign  = w_sh[15];
            end
            SZ_W: begin
                w_width = 32;
                w_sign  = w_sh[31];
            end
            default: begin
                w_width = XLEN;
                w_sign  = w_sh[XLEN-1];
            end
        endcase
    end

    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            o_data[i] = (i < w_width) ? w_sh[i] : (w_sign & ~i_unsigned);
        end
    end

endmodule

// File: rtl/mem_stage_ls.sv
// Pipeline MEM stage with MEM/WB register: sub-word loads/stores over a req/ready bus.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ls
    import cpu_mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic [XLEN-1:0]    ex_alu_out,
    input  logic               ex_reg_write,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic               ex_mem_to_reg,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [1:0]         ex_size,
    input  logic               ex_unsigned,
    input  logic [XLEN-1:0]    ex_store_data,
    input  logic               fwd_sel,
    input  logic [XLEN-1:0]    fwd_wb_data,
    mem_stage_ls_if.master     dmem,
    output logic               mem_stall,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [XLEN-1:0]    wb_load_data,
    output logic [XLEN-1:0]    wb_alu_out,
    output logic               wb_misalign,
    output logic               wb_bus_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    if (!(XLEN == 32 || XLEN == 64) || MAX_WAIT < 1) begin : g_bad_cfg
        $error("mem_stage_ls: XLEN must be 32 or 64 and MAX_WAIT at least 1");
    end

    state_e            r_state;
    state_e            w_next;
    size_e             w_size;
    logic [OFFW-1:0]   w_off;
    logic              w_is_mem;
    logic              w_ok;
    logic              w_acc;
    logic              w_misalign;
    logic              w_stall;
    logic              w_done;
    logic              w_timeout;
    logic [XLEN-1:0]   w_sdata;
    logic [XLEN-1:0]   w_wdata;
    logic [NB-1:0]     w_mask;
    logic [NB-1:0]     w_be_st;
    logic [XLEN-1:0]   w_load;

    assign w_size   = size_e'(ex_size);
    assign w_off    = ex_alu_out[OFFW-1:0];
    assign w_is_mem = ex_valid & (ex_mem_read | ex_mem_write);

    // Double-word accesses only exist on a 64-bit datapath; otherwise they
    // are reported exactly like a misaligned access.
    always_comb begin
        w_ok = 1'b0;
        case (w_size)
            SZ_B:    w_ok = 1'b1;
            SZ_H:    w_ok = ~w_off[0];
            SZ_W:    w_ok = (w_off[1:0] == 2'b00);
            default: w_ok = (XLEN == 64) && (w_off == '0);
        endcase
    end

    assign w_acc      = w_is_mem & w_ok;
    assign w_misalign = w_is_mem & ~w_ok;

    // Store path: lane-replicated data and offset-shifted byte enables.
    assign w_sdata = fwd_sel ? fwd_wb_data : ex_store_data;

    always_comb begin
        w_wdata = w_sdata;
        case (w_size)
            SZ_B:    w_wdata = {NB{w_sdata[7:0]}};
            SZ_H:    w_wdata = {(NB/2){w_sdata[15:0]}};
            SZ_W:    w_wdata = {(NB/4){w_sdata[31:0]}};
            default: w_wdata = w_sdata;
        endcase
    end

    assign w_mask  = NB'(be_mask(w_size));
    assign w_be_st = w_mask << w_off;

    mem_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata    (dmem.dmem_rdata),
        .i_offset   (w_off),
        .i_size     (w_size),
        .i_unsigned (ex_unsigned),
        .o_data     (w_load)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_wait_cnt;

    assign w_timeout = (r_state == ST_WAIT) & w_acc & ~dmem.dmem_ready &
                       (r_wait_cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && w_acc && !dmem.dmem_ready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_done  = w_acc & dmem.dmem_ready;
        w_stall = w_acc & ~dmem.dmem_ready & ~w_timeout;
        case (r_state)
            ST_IDLE: if (w_stall)  w_next = ST_WAIT;
            ST_WAIT: if (!w_stall) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request outputs are forced low during reset so an abandoned access
    // drops off the bus immediately.
    assign dmem.dmem_req   = w_acc & ~reset;
    assign dmem.dmem_we    = w_acc & ex_mem_write & ~reset;
    assign dmem.dmem_be    = (reset || !w_acc) ? '0 : (ex_mem_write ? w_be_st : '1);
    assign dmem.dmem_addr  = {ex_alu_out[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign dmem.dmem_wdata = w_wdata;
    assign mem_stall       = w_stall & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_load_data  <= '0;
            wb_alu_out    <= '0;
            wb_misalign   <= 1'b0;
            wb_bus_err    <= 1'b0;
        end else if (w_stall) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_load_data  <= '0;
            wb_alu_out    <= '0;
            wb_misalign   <= 1'b0;
            wb_bus_err    <= 1'b0;
        end else begin
            wb_valid      <= ex_valid;
            wb_reg_write  <= ex_reg_write & ~w_misalign & ~w_timeout;
            wb_mem_to_reg <= ex_mem_to_reg;
            wb_rd         <= ex_rd;
            wb_load_data  <= (w_done && ex_mem_read && !ex_mem_write) ? w_load : '0;
            wb_alu_out    <= ex_alu_out;
            wb_misalign   <= w_misalign;
            wb_bus_err    <= w_timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Scoreboard bench for mem_stage_ls (XLEN=32); timeout case runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ls;
    import cpu_mem_pkg::*;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic        m2r;
        logic [31:0] ld;
        logic [31:0] alu;
        logic        mis;
        logic        berr;
    } wb_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_alu_out;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_to_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [1:0]        ex_size;
    logic              ex_unsigned;
    logic [XLEN-1:0]   ex_store_data;
    logic              fwd_sel;
    logic [XLEN-1:0]   fwd_wb_data;
    logic              mem_stall;
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_load_data;
    logic [XLEN-1:0]   wb_alu_out;
    logic              wb_misalign;
    logic              wb_bus_err;

    wb_t         sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_stage_ls_if #(.XLEN(XLEN)) dmem_bus ();

    mem_stage_ls #(
        .XLEN     (XLEN),
        .REG_AW   (REG_AW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_store_data (ex_store_data),
        .fwd_sel       (fwd_sel),
        .fwd_wb_data   (fwd_wb_data),
        .dmem          (dmem_bus),
        .mem_stall     (mem_stall),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_load_data  (wb_load_data),
        .wb_alu_out    (wb_alu_out),
        .wb_misalign   (wb_misalign),
        .wb_bus_err    (wb_bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every valid WB bundle must match the oldest expected entry.
    always @(posedge clk) begin
        wb_t e;
        #2;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("wb_reg_write",  wb_reg_write,  e.rw);
                check("wb_rd",         wb_rd,         e.rd);
                check("wb_mem_to_reg", wb_mem_to_reg, e.m2r);
                check("wb_load_data",  wb_load_data,  e.ld);
                check("wb_alu_out",    wb_alu_out,    e.alu);
                check("wb_misalign",   wb_misalign,   e.mis);
                check("wb_bus_err",    wb_bus_err,    e.berr);
            end
        end
    end

    task automatic go_idle(input int n);
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        dmem_bus.dmem_ready = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Drives one instruction, serves it with n_stall wait cycles (ready is
    // raised on the last one only if ready_ends), and checks the bus side.
    task automatic issue(
        input logic rd_op, input logic wr_op, input logic [1:0] sz, input logic uns,
        input logic [31:0] addr, input logic [31:0] sdata, input logic fsel,
        input logic [31:0] fdata, input logic [31:0] rdata, input int n_stall,
        input logic ready_ends, input logic [4:0] rd, input logic rw,
        input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
        input logic [31:0] exp_ld, input logic exp_mis, input logic exp_berr);
        wb_t e;
        @(negedge clk);
        ex_valid      = 1'b1;
        ex_alu_out    = addr;
        ex_reg_write  = rw;
        ex_rd         = rd;
        ex_mem_to_reg = rd_op;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_size       = sz;
        ex_unsigned   = uns;
        ex_store_data = sdata;
        fwd_sel       = fsel;
        fwd_wb_data   = fdata;
        dmem_bus.dmem_ready = (n_stall == 0);
        dmem_bus.dmem_rdata = (n_stall == 0) ? rdata : 32'h0;
        e = '{rw & ~exp_mis & ~exp_berr, rd, rd_op, exp_ld, addr, exp_mis, exp_berr};
        sb_q.push_back(e);
        for (int c = 0; c <= n_stall; c++) begin
            #1;
            check("dmem_req", dmem_bus.dmem_req, exp_req);
            check("dmem_we",  dmem_bus.dmem_we,  exp_req & wr_op);
            check("dmem_be",  dmem_bus.dmem_be,  exp_be);
            if (exp_req) check("dmem_addr", dmem_bus.dmem_addr, addr & 32'hFFFF_FFFC);
            if (exp_req && wr_op) check("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
            check("mem_stall", mem_stall, c < n_stall);
            if (c < n_stall) begin
                @(posedge clk);
                #1;
                check("bubble_valid", wb_valid, 0);
                check("bubble_rw",    wb_reg_write, 0);
                @(negedge clk);
                if (ready_ends && (c + 1 == n_stall)) begin
                    dmem_bus.dmem_ready = 1'b1;
                    dmem_bus.dmem_rdata = rdata;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, summary %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b1;
        ex_alu_out    = 32'h100;
        ex_reg_write  = 1'b1;
        ex_rd         = 5'd1;
        ex_mem_to_reg = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_size       = SZ_W;
        ex_unsigned   = 1'b0;
        ex_store_data = 32'h0;
        fwd_sel       = 1'b0;
        fwd_wb_data   = 32'h0;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;

        #2;
        check("rst_req",   dmem_bus.dmem_req, 0);
        check("rst_be",    dmem_bus.dmem_be, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_rw",    wb_reg_write, 0);
        check("rst_ld",    wb_load_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        reset    = 1'b0;
        go_idle(1);

        //     rd wr size  uns addr          sdata         fs fdata         rdata         st rdy rd     rw req be       wdata         ld            mis berr
        issue(1, 0, SZ_W, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 1, 5'd1, 1, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
        issue(1, 0, SZ_B, 0, 32'h0000_0103, 32'h0,        0, 32'h0,        32'h80112233, 0, 1, 5'd2, 1, 1, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0);
        issue(1, 0, SZ_B, 1, 32'h0000_0103, 32'h0,        0, 32'h0,        32'h80112233, 0, 1, 5'd3, 1, 1, 4'b1111, 32'h0,        32'h00000080, 0, 0);
        issue(1, 0, SZ_H, 0, 32'h0000_0102, 32'h0,        0, 32'h0,        32'h80112233, 0, 1, 5'd4, 1, 1, 4'b1111, 32'h0,        32'hFFFF8011, 0, 0);
        issue(1, 0, SZ_H, 1, 32'h0000_0200, 32'h0,        0, 32'h0,        32'h1234A5A5, 0, 1, 5'd5, 1, 1, 4'b1111, 32'h0,        32'h0000A5A5, 0, 0);
        issue(0, 1, SZ_H, 0, 32'h0000_0102, 32'h1234ABCD, 1, 32'h0000BEEF, 32'h0,        0, 1, 5'd0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0);
        issue(0, 1, SZ_B, 0, 32'h0000_0101, 32'h000000A5, 0, 32'hDEADDEAD, 32'h0,        0, 1, 5'd0, 0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0);
        issue(0, 1, SZ_W, 0, 32'h0000_0200, 32'h11223344, 0, 32'h0,        32'h0,        2, 1, 5'd0, 0, 1, 4'b1111, 32'h11223344, 32'h0,        0, 0);
        issue(1, 0, SZ_W, 0, 32'h0000_0104, 32'h0,        0, 32'h0,        32'hCAFEF00D, 3, 1, 5'd6, 1, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0);
        issue(1, 0, SZ_W, 0, 32'h0000_0108, 32'h0,        0, 32'h0,        32'h01234567, 0, 1, 5'd7, 1, 1, 4'b1111, 32'h0,        32'h01234567, 0, 0);
        issue(1, 0, SZ_W, 0, 32'h0000_0102, 32'h0,        0, 32'h0,        32'h0,        0, 0, 5'd8, 1, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
        issue(1, 0, SZ_H, 0, 32'h0000_0101, 32'h0,        0, 32'h0,        32'h0,        0, 0, 5'd9, 1, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
        issue(1, 0, SZ_D, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        32'h0,        0, 0, 5'd10, 1, 0, 4'b0000, 32'h0,       32'h0,        1, 0);
        issue(0, 0, SZ_W, 0, 32'h0000_0055, 32'h0,        0, 32'h0,        32'h0,        0, 0, 5'd11, 1, 0, 4'b0000, 32'h0,       32'h0,        0, 0);
        go_idle(2);

`ifdef MEM_TIMEOUT_EN
        // Never ready: MAX_WAIT+1 stalled cycles, then the bundle leaves with a bus error.
        issue(1, 0, SZ_W, 0, 32'h0000_0300, 32'h0, 0, 32'h0, 32'h0, MAX_WAIT + 1, 0, 5'd12, 1, 1, 4'b1111, 32'h0, 32'h0, 0, 1);
        go_idle(2);
`endif

        // Reset in the middle of a waiting load abandons it; a late ready is ignored.
        @(negedge clk);
        ex_valid      = 1'b1;
        ex_alu_out    = 32'h400;
        ex_reg_write  = 1'b1;
        ex_rd         = 5'd13;
        ex_mem_to_reg = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_size       = SZ_W;
        dmem_bus.dmem_ready = 1'b0;
        #1;
        check("wait_stall0", mem_stall, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wait_stall1", mem_stall, 1);
        check("wait_req1",   dmem_bus.dmem_req, 1);
        reset = 1'b1;
        #1;
        check("midrst_req",   dmem_bus.dmem_req, 0);
        check("midrst_stall", mem_stall, 0);
        check("midrst_be",    dmem_bus.dmem_be, 0);
        check("midrst_valid", wb_valid, 0);
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hBAD0BAD0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("late_ready_valid", wb_valid, 0);
        check("late_ready_ld",    wb_load_data, 0);
        go_idle(1);

        issue(1, 0, SZ_W, 0, 32'h0000_0110, 32'h0, 0, 32'h0, 32'h5A5A1234, 1, 1, 5'd14, 1, 1, 4'b1111, 32'h0, 32'h5A5A1234, 0, 0);
        go_idle(3);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
